aexm_ibuf: RTL
==============

AEXM_IBUF -- requirements
Module: aexm_ibuf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning instruction FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have port gclk, input, 1, system clock; all state changes on posedge.
REQ-003 The block SHALL have port grst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port d_en, input, 1, decode-advance enable shared with the control stage.
REQ-005 The block SHALL have port i_valid, input, 1, instruction cache word valid this cycle.
REQ-006 The block SHALL have port aexm_icache_datai, input, 32, fetched instruction word.
REQ-007 The block SHALL have port i_ready, output, 1, FIFO can accept a word this cycle.
REQ-008 The block SHALL have port bFLUSH, input, 1, taken branch or interrupt; discards buffered words.
REQ-009 The block SHALL have port xIREG, output, 32, instruction presented to the control stage.
REQ-010 The block SHALL have port x_valid, output, 1, xIREG holds a real instruction.
REQ-011 The block SHALL have ports rOPC/rRD/rRA/rRB/rALT/rIMM, outputs, 6/5/5/5/11/16, registered fields of the last issued word.
REQ-012 The block SHALL have port rSIMM, output, 32, effective immediate after IMM-prefix merge.
REQ-013 The block SHALL have port xINT_OK, output, 1, interrupt may be taken at the current boundary.

Function
REQ-014 Push SHALL occur when i_valid && i_ready && !bFLUSH; i_ready SHALL be (count < DEPTH).
REQ-015 Pop SHALL occur when d_en && x_valid && !bFLUSH; simultaneous push and pop SHALL leave count unchanged.
REQ-016 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-017 x_valid SHALL be (count != 0); xIREG SHALL be the head entry when x_valid, else 32'h0.
REQ-018 On d_en, {rOPC,rRD,rRA,rRB,rALT} SHALL load xIREG fields [31:26],[25:21],[20:16],[15:11],[10:0] and rIMM SHALL load xIREG[15:0]; when !x_valid all SHALL load zero.
REQ-019 Prefix state imm_hold (1 bit) and imm_hi (16 bits): a pop of opcode 6'o54 SHALL set imm_hold=1 and imm_hi=xIREG[15:0]; any other pop SHALL clear imm_hold.
REQ-020 On d_en, rSIMM SHALL load {imm_hi, xIREG[15:0]} when imm_hold=1, else sign-extended xIREG[15:0].
REQ-021 xINT_OK SHALL be !imm_hold && !(x_valid && xIREG[31:26]==6'o54), so interrupts never split a prefix pair.
REQ-022 bFLUSH SHALL clear count, pointers and imm_hold on the same edge, overriding push and pop; registered r* fields SHALL still update per REQ-018 if d_en.
REQ-023 With d_en low, the FIFO SHALL still accept pushes until full, and all r* outputs SHALL hold.
REQ-024 A full FIFO SHALL drop nothing: i_ready=0 and the cache holds its word.

Reset
REQ-025 grst_n low SHALL asynchronously clear count, pointers, imm_hold, imm_hi, all r* outputs and rSIMM to zero; FIFO storage need not reset.
REQ-026 After reset: i_ready=1, x_valid=0, xIREG=0, xINT_OK=1.
REQ-027 Reset asserted mid-stream SHALL discard all buffered words with no partial pop.

Configuration
REQ-028 With AEXM_IBUF_BYPASS_EN defined, when count==0 and i_valid, xIREG SHALL equal aexm_icache_datai combinationally and x_valid=1; a d_en in that cycle consumes the word without a push.
REQ-029 Without AEXM_IBUF_BYPASS_EN, every word SHALL spend at least one cycle in the FIFO; empty-to-x_valid latency is one cycle.

Verification
REQ-030 The bench SHALL cover reset and back-to-back streaming: push 32'hA0000001, 32'hA0000002 with d_en=1 -> xIREG sequence matches, rOPC=6'o50, count never exceeds 1.
REQ-031 The bench SHALL cover full and stall: d_en=0, push 3 words with DEPTH=2 -> i_ready=0 after 2 words, third held, none lost after d_en resumes.
REQ-032 The bench SHALL cover IMM merge: pop 32'hB0001234 then 32'h2020FFF0 -> rSIMM=32'h1234FFF0; xINT_OK=0 while the prefix is head or imm_hold=1.
REQ-033 The bench SHALL cover flush collision: bFLUSH with simultaneous push and pop at count=2 -> count=0, x_valid=0, imm_hold=0 next cycle.
REQ-034 The bench SHALL cover async reset mid-stream: grst_n low between edges -> outputs zero immediately, i_ready=1.
REQ-035 The bench SHALL cover the bypass build: empty FIFO, i_valid with 32'h30000007 and d_en=1 -> rIMM=16'h0007 on the next edge; with the macro absent the same word issues one cycle later.

Source files
------------

// File: rtl/aexm_ibuf.sv
// Instruction buffer between the I-cache and the control stage: small FIFO, issue registers, IMM-prefix merge.
// Define AEXM_IBUF_BYPASS_EN to let a word reach xIREG combinationally when the FIFO is empty.
module aexm_ibuf #(
  parameter int DEPTH = 2
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        d_en,
  input  logic        i_valid,
  input  logic [31:0] aexm_icache_datai,
  output logic        i_ready,
  input  logic        bFLUSH,
  output logic [31:0] xIREG,
  output logic        x_valid,
  output logic [5:0]  rOPC,
  output logic [4:0]  rRD,
  output logic [4:0]  rRA,
  output logic [4:0]  rRB,
  output logic [10:0] rALT,
  output logic [15:0] rIMM,
  output logic [31:0] rSIMM,
  output logic        xINT_OK
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [5:0]  OPC_IMM = 6'o54;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0]   count;
  logic          immHold;
  logic [15:0]   immHi;

  logic empty, bypass, pop, fifoPop, push;

  always_comb begin
    empty = (count == '0);
`ifdef AEXM_IBUF_BYPASS_EN
    bypass = empty && i_valid;
`else
    bypass = 1'b0;
`endif
    i_ready = (count < FULL);
    x_valid = !empty || bypass;
    xIREG   = '0;
    if (!empty)
      xIREG = mem[rdPtr];
    else if (bypass)
      xIREG = aexm_icache_datai;
    pop     = d_en && x_valid && !bFLUSH;
    fifoPop = pop && !empty;
    // A bypassed word that is issued this cycle never enters the FIFO.
    push    = i_valid && i_ready && !bFLUSH && !(bypass && pop);
    xINT_OK = !immHold && !(x_valid && xIREG[31:26] == OPC_IMM);
  end

  always_ff @(posedge gclk) begin
    if (push)
      mem[wrPtr] <= aexm_icache_datai;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      immHold <= 1'b0;
      immHi   <= '0;
    end else if (bFLUSH) begin
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      immHold <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (fifoPop)
        rdPtr <= rdPtr + 1'b1;
      if (push && !fifoPop)
        count <= count + 1'b1;
      else if (fifoPop && !push)
        count <= count - 1'b1;
      if (pop) begin
        immHold <= (xIREG[31:26] == OPC_IMM);
        if (xIREG[31:26] == OPC_IMM)
          immHi <= xIREG[15:0];
      end
    end
  end

  // Issue registers follow d_en even during a flush; xIREG is zero when nothing is valid.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rOPC  <= '0;
      rRD   <= '0;
      rRA   <= '0;
      rRB   <= '0;
      rALT  <= '0;
      rIMM  <= '0;
      rSIMM <= '0;
    end else if (d_en) begin
      rOPC  <= xIREG[31:26];
      rRD   <= xIREG[25:21];
      rRA   <= xIREG[20:16];
      rRB   <= xIREG[15:11];
      rALT  <= xIREG[10:0];
      rIMM  <= xIREG[15:0];
      rSIMM <= immHold ? {immHi, xIREG[15:0]} : {{16{xIREG[15]}}, xIREG[15:0]};
    end
  end

endmodule
